hazard_stall_unit: RTL
======================

// Module: hazard_stall_unit
// PURPOSE
//  Produces the single `stall` request consumed by the pipeline stall controller (PC/IF-ID freeze, control bubble).
//  Merges three hazard sources: load-use RAW hazards between ID and EX, multi-cycle MDU (mul/div) occupancy, and data-memory wait states.
//  Also drives `freeze_back`, which holds EX/MEM/WB during MDU and memory waits.
//  Keeps a saturating stall-cycle counter for performance monitoring.
// PARAMETERS
//  REG_AW       5   register-index width
//  MDU_LATENCY  4   total EX cycles for an MDU op (>=2)
//  MEM_TIMEOUT  64  wait cycles before mem_timeout fires (>=2)
//  CNT_W        32  width of stall_cycles
// PORTS
//  clk           in   1       rising-edge clock
//  rst_n         in   1       asynchronous active-low reset
//  id_valid      in   1       ID holds a real instruction
//  id_rs1        in   REG_AW  ID source register 1
//  id_rs2        in   REG_AW  ID source register 2
//  id_uses_rs1   in   1       ID instruction reads rs1
//  id_uses_rs2   in   1       ID instruction reads rs2
//  ex_rd         in   REG_AW  EX destination register
//  ex_mem_read   in   1       EX instruction is a load
//  ex_mdu_start  in   1       MDU op entered EX this cycle (1-cycle pulse)
//  mem_req       in   1       MEM stage issues a data access
//  mem_ready     in   1       data memory completes access this cycle
//  stall         out  1       to stall controller; freeze PC/IF-ID, bubble ID/EX
//  freeze_back   out  1       hold EX/MEM/WB registers
//  stall_cause   out  2       0 none, 1 load-use, 2 MDU, 3 memory
//  mem_timeout   out  1       1-cycle error pulse
//  stall_cycles  out  CNT_W   saturating count of cycles with stall=1
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - state=S_RUN, mdu_cnt=0, wait_cnt=0, stall_cycles=0, mem_timeout=0.
//   - All combinational outputs are 0 while in reset.
//  Load-use detect (comb):
//   - lu = id_valid & ex_mem_read & ex_rd!=0 & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
//   - Asserts stall in the same cycle. Does not assert freeze_back; the load advances, so lu drops on the next cycle.
//  FSM states S_RUN, S_MDU, S_MEM:
//   - S_RUN: mem_req & !mem_ready -> S_MEM, wait_cnt=1.
//     Otherwise ex_mdu_start -> S_MDU, mdu_cnt=MDU_LATENCY-1.
//     Otherwise stay.
//   - S_MDU: mdu_cnt decrements each cycle. When mdu_cnt==1, next state is S_RUN.
//     MDU occupies exactly MDU_LATENCY EX cycles, including the start cycle.
//     ex_mdu_start is ignored in S_MDU.
//   - S_MEM: mem_ready -> S_RUN, wait_cnt=0.
//     wait_cnt==MEM_TIMEOUT-1 & !mem_ready -> mem_timeout=1 for one cycle, then S_RUN (releases the pipeline).
//     Otherwise wait_cnt++.
//  Comb outputs:
//   - mdu_busy = (S_RUN & ex_mdu_start) | S_MDU.
//   - mem_busy = (mem_req & !mem_ready & state!=S_MDU) | (S_MEM & !mem_ready).
//   - freeze_back = mdu_busy | mem_busy.
//   - stall = lu | freeze_back.
//   - stall_cause priority: memory(3) > MDU(2) > load-use(1) > 0.
//  Simultaneous events:
//   - mem_req wait and ex_mdu_start in S_RUN: enter S_MEM. The MDU op stays frozen in EX; EX re-pulses ex_mdu_start after release.
//   - mem_ready in the same cycle as the timeout compare: ready wins, no mem_timeout.
//   - lu with freeze_back: stall=1, cause per priority.
//  stall_cycles: +1 on every cycle with stall=1; holds at all-ones (no wrap).
//  Reset mid-operation: aborts S_MDU/S_MEM immediately; stall deasserts asynchronously.
// TESTING
//  - Load-use: ex_mem_read=1, ex_rd=5, id_rs1=5, id_uses_rs1=1, id_valid=1 for 1 cycle
//    -> stall=1, cause=1, freeze_back=0. With ex_rd=0 -> stall=0.
//  - MDU, MDU_LATENCY=4: ex_mdu_start pulse at cycle 0 -> stall=freeze_back=1 in cycles 0..3, 0 in cycle 4.
//    stall_cycles increases by 4.
//  - Memory wait: mem_req=1, mem_ready=0 for 3 cycles, then 1 -> stall=1 for 3 cycles, cause=3, deasserts in the ready cycle.
//  - Timeout, MEM_TIMEOUT=8: mem_ready held 0 -> one-cycle mem_timeout pulse in the 8th wait cycle, then state=S_RUN.
//    mem_ready=1 in the 8th cycle -> no pulse.
//  - Collision: ex_mdu_start and a memory wait in the same cycle -> S_MEM, cause=3. After ready plus a re-pulse, the MDU stalls for 4 cycles.
//  - Reset in cycle 2 of S_MDU -> stall=0 immediately, stall_cycles=0. Saturation: preload all-ones, stall 1 cycle -> value unchanged.

Source files
------------

// File: rtl/hazard_stall_unit_if.sv
// Hazard-source inputs and stall outputs exchanged between the pipeline and hazard_stall_unit.
// The pipeline side is the master; the hazard unit is the slave.
interface hazard_stall_unit_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
);
  logic              id_valid;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic              id_uses_rs1;
  logic              id_uses_rs2;
  logic [REG_AW-1:0] ex_rd;
  logic              ex_mem_read;
  logic              ex_mdu_start;
  logic              mem_req;
  logic              mem_ready;
  logic              stall;
  logic              freeze_back;
  logic [1:0]        stall_cause;
  logic              mem_timeout;
  logic [CNT_W-1:0]  stall_cycles;

  modport master (
    output id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
           ex_rd, ex_mem_read, ex_mdu_start, mem_req, mem_ready,
    input  stall, freeze_back, stall_cause, mem_timeout, stall_cycles
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
           ex_rd, ex_mem_read, ex_mdu_start, mem_req, mem_ready,
    output stall, freeze_back, stall_cause, mem_timeout, stall_cycles
  );
endinterface

// File: rtl/hazard_stall_unit.sv
// Merges load-use, MDU-occupancy and memory-wait hazards into one stall request,
// with a back-end freeze, a cause code, a memory timeout pulse and a saturating stall counter.
module hazard_stall_unit #(
  parameter int REG_AW      = 5,
  parameter int MDU_LATENCY = 4,
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input logic               clk,
  input logic               rst_n,
  hazard_stall_unit_if.slave bus
);
  localparam int MW = $clog2(MDU_LATENCY + 1);
  localparam int WW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [MW-1:0] MDU_LOAD  = MW'(MDU_LATENCY - 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(MEM_TIMEOUT - 1);

  typedef enum logic [1:0] {S_RUN, S_MDU, S_MEM} state_t;

  state_t           state;
  logic [MW-1:0]    mdu_cnt;
  logic [WW-1:0]    wait_cnt;
  logic [CNT_W-1:0] stall_cycles;
  logic             lu;
  logic             mdu_busy;
  logic             mem_busy;
  logic             stall;
  logic             timeout_hit;

  // Every combinational output is gated by rst_n so nothing leaks out while reset is held.
  always_comb begin
    lu = bus.id_valid && bus.ex_mem_read && (bus.ex_rd != '0) &&
         ((bus.id_uses_rs1 && (bus.id_rs1 == bus.ex_rd)) ||
          (bus.id_uses_rs2 && (bus.id_rs2 == bus.ex_rd)));
    mdu_busy = ((state == S_RUN) && bus.ex_mdu_start) || (state == S_MDU);
    mem_busy = (bus.mem_req && !bus.mem_ready && (state != S_MDU)) ||
               ((state == S_MEM) && !bus.mem_ready);
    timeout_hit = (state == S_MEM) && (wait_cnt == WAIT_LAST) && !bus.mem_ready;
    stall = rst_n && (lu || mdu_busy || mem_busy);

    bus.freeze_back = rst_n && (mdu_busy || mem_busy);
    bus.stall       = stall;
    bus.mem_timeout = rst_n && timeout_hit;
    bus.stall_cause = 2'd0;
    if (rst_n) begin
      if (mem_busy)      bus.stall_cause = 2'd3;
      else if (mdu_busy) bus.stall_cause = 2'd2;
      else if (lu)       bus.stall_cause = 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_RUN;
      mdu_cnt  <= '0;
      wait_cnt <= '0;
    end else begin
      case (state)
        S_RUN: begin
          // A memory wait takes precedence; a colliding MDU op is re-pulsed by EX later.
          if (bus.mem_req && !bus.mem_ready) begin
            state    <= S_MEM;
            wait_cnt <= WW'(1);
          end else if (bus.ex_mdu_start) begin
            state   <= S_MDU;
            mdu_cnt <= MDU_LOAD;
          end
        end
        S_MDU: begin
          if (mdu_cnt == MW'(1)) begin
            state   <= S_RUN;
            mdu_cnt <= '0;
          end else begin
            mdu_cnt <= mdu_cnt - MW'(1);
          end
        end
        S_MEM: begin
          if (bus.mem_ready || (wait_cnt == WAIT_LAST)) begin
            state    <= S_RUN;
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt + WW'(1);
          end
        end
        default: state <= S_RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
    end else if (stall && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end

  assign bus.stall_cycles = stall_cycles;
endmodule
